// File: rtl/press_gen_pkg.sv
// Shared types and constants for the button press pattern generator.
// Optional feature macro: PRESS_BOUNCE_EN (contact-bounce emulation at press start).
package press_gen_pkg;

    localparam int BTN_W     = 6;   // width of the emulated button bus
    localparam int MS_CNT_W  = 16;  // width of the millisecond counter
    localparam int BOUNCE_MS = 4;   // number of 1 ms bounce slots at the start of a press

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2
    } state_e;

    // Terminal value of the ms counter for a duration of 'ms' milliseconds
    // (the counter runs 0 .. ms-1 and the phase ends on the tick at ms-1).
    function automatic logic [MS_CNT_W-1:0] ms_last(input int unsigned ms);
        return MS_CNT_W'(ms - 1);
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: one-cycle tick every TICK_DIV clocks, restartable
// with a synchronous clear. pre_tick fires one cycle ahead of tick so the
// owner can end a phase with a registered output landing on the tick cycle.
module ms_tick_gen #(
    parameter int TICK_DIV = 25000
) (
    input  logic clock,
    input  logic rst,
    input  logic clr,
    output logic tick,
    output logic pre_tick
);

    localparam int W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] CNT_LAST = W'(TICK_DIV - 1);
    localparam logic [W-1:0] CNT_PRE  = W'(TICK_DIV - 2);

    logic [W-1:0] cnt_q, cnt_d;

    // Next prescaler value: clear wins, otherwise count 0 .. TICK_DIV-1 and wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Prescaler register.
    always_ff @(posedge clock) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick     = (cnt_q == CNT_LAST);
    assign pre_tick = (cnt_q == CNT_PRE);

endmodule

// File: rtl/press_pattern_gen.sv
// Button press pattern generator: accepts a (mask, short/long) command,
// drives the mask onto button_out for the press duration, then forces a
// release gap and pulses done. The done cycle is the final cycle of the gap,
// with the FSM already back in IDLE, so a held cmd_valid starts the next
// press in the very next cycle.
// Optional feature macro: PRESS_BOUNCE_EN -- the first 4 ms of each press
// alternate mask/0 per ms to mimic contact bounce (press length unchanged).
module press_pattern_gen
    import press_gen_pkg::*;
#(
    parameter int TICK_DIV = 25000,
    parameter int SHORT_MS = 200,
    parameter int LONG_MS  = 1500,
    parameter int GAP_MS   = 100
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [5:0] cmd_mask,
    input  logic       cmd_long,
    output logic [5:0] button_out,
    output logic       busy,
    output logic       done
);

    localparam logic [MS_CNT_W-1:0] SHORT_LAST = ms_last(SHORT_MS);
    localparam logic [MS_CNT_W-1:0] LONG_LAST  = ms_last(LONG_MS);
    localparam logic [MS_CNT_W-1:0] GAP_LAST   = ms_last(GAP_MS);

    state_e              state_q, state_d;
    logic [BTN_W-1:0]    mask_q, mask_d;
    logic [MS_CNT_W-1:0] dur_last_q, dur_last_d;
    logic [MS_CNT_W-1:0] ms_cnt_q, ms_cnt_d;
    logic                done_q, done_d;

    logic accept;
    logic tick;
    logic pre_tick;

    assign cmd_ready = (state_q == IDLE) && !rst;
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

    // Prescaler restarts on accept so the first ms of the press is a full ms.
    ms_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_ms_tick (
        .clock    (clock),
        .rst      (rst),
        .clr      (accept),
        .tick     (tick),
        .pre_tick (pre_tick)
    );

    // FSM next state, command latch, ms counter and done pulse.
    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        dur_last_d = dur_last_q;
        ms_cnt_d   = tick ? (ms_cnt_q + MS_CNT_W'(1)) : ms_cnt_q;
        done_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                ms_cnt_d = '0;
                if (accept) begin
                    mask_d     = cmd_mask;
                    dur_last_d = cmd_long ? LONG_LAST : SHORT_LAST;
                    if (cmd_mask != '0) begin
                        state_d = PRESS;
                    end else begin
                        // Nothing to press: complete immediately, no gap.
                        done_d = 1'b1;
                    end
                end
            end

            PRESS: begin
                if (tick && (ms_cnt_q == dur_last_q)) begin
                    state_d  = GAP;
                    ms_cnt_d = '0;
                end
            end

            GAP: begin
                // Leave one cycle before the last tick: the done cycle is
                // itself the final gap cycle (button_out is 0 in IDLE too).
                if (pre_tick && (ms_cnt_q == GAP_LAST)) begin
                    state_d  = IDLE;
                    done_d   = 1'b1;
                    ms_cnt_d = '0;
                end
            end

            default: begin
                state_d  = IDLE;
                ms_cnt_d = '0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q    <= IDLE;
            mask_q     <= '0;
            dur_last_q <= '0;
            ms_cnt_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            dur_last_q <= dur_last_d;
            ms_cnt_q   <= ms_cnt_d;
            done_q     <= done_d;
        end
    end

    // Button drive: mask during PRESS, optionally gated by the bounce pattern.
    always_comb begin
        button_out = '0;
        if (state_q == PRESS) begin
            button_out = mask_q;
`ifdef PRESS_BOUNCE_EN
            // Odd ms slots inside the bounce window read as released.
            if ((ms_cnt_q < MS_CNT_W'(BOUNCE_MS)) && ms_cnt_q[0]) begin
                button_out = '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_press_pattern_gen.sv
// Self-checking bench for press_pattern_gen. A cycle-indexed model derives
// expected outputs from accept times and phase lengths; a per-cycle logger
// also feeds hand-computed literal checks for each scenario.
module tb_press_pattern_gen;

    localparam int TDIV = 4;
`ifdef PRESS_BOUNCE_EN
    localparam int SMS  = 5;
`else
    localparam int SMS  = 3;
`endif
    localparam int LMS  = 10;
    localparam int GMS  = 2;
    localparam int LOGN = 2048;

    logic       clock = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [5:0] cmd_mask;
    logic       cmd_long;
    logic [5:0] button_out;
    logic       busy;
    logic       done;

    press_pattern_gen #(
        .TICK_DIV (TDIV),
        .SHORT_MS (SMS),
        .LONG_MS  (LMS),
        .GAP_MS   (GMS)
    ) dut (
        .clock      (clock),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_mask   (cmd_mask),
        .cmd_long   (cmd_long),
        .button_out (button_out),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    logic [5:0] log_btn   [LOGN];
    logic       log_busy  [LOGN];
    logic       log_done  [LOGN];
    logic       log_ready [LOGN];

    // Model: one outstanding press described by its accept cycle and lengths.
    bit         m_active = 0;
    int         m_acc    = 0;
    int         m_plen   = 0;
    int         m_done   = -1;
    int         m_zdone  = -1;
    logic [5:0] m_mask   = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit m_busy(input int n);
        return m_active && (n > m_acc) && (n < m_done);
    endfunction

    function automatic logic [5:0] m_btn(input int n);
        int k;
        if (!(m_active && (n > m_acc) && (n <= m_acc + m_plen))) return 6'd0;
        k = n - (m_acc + 1);
`ifdef PRESS_BOUNCE_EN
        if (((k / TDIV) < 4) && (((k / TDIV) % 2) == 1)) return 6'd0;
`endif
        return m_mask;
    endfunction

    // Per-cycle compare against the model, then advance the model at the edge.
    initial begin
        forever begin
            @(negedge clock);
            if (cyc >= 1) begin
                if (cyc < LOGN) begin
                    log_btn[cyc]   = button_out;
                    log_busy[cyc]  = busy;
                    log_done[cyc]  = done;
                    log_ready[cyc] = cmd_ready;
                end
                chk($sformatf("c%0d button_out", cyc), 32'(button_out), 32'(m_btn(cyc)));
                chk($sformatf("c%0d busy", cyc), 32'(busy), 32'(m_busy(cyc)));
                chk($sformatf("c%0d done", cyc), 32'(done),
                    32'((m_active && cyc == m_done) || cyc == m_zdone));
                chk($sformatf("c%0d cmd_ready", cyc), 32'(cmd_ready),
                    32'(!rst && !m_busy(cyc)));
            end
            @(posedge clock);
            if (rst) begin
                m_active = 0;
                m_zdone  = -1;
            end else if (cmd_valid && !m_busy(cyc)) begin
                if (cmd_mask != 6'd0) begin
                    m_active = 1;
                    m_acc    = cyc;
                    m_mask   = cmd_mask;
                    m_plen   = (cmd_long ? LMS : SMS) * TDIV;
                    m_done   = cyc + m_plen + GMS * TDIV;
                end else begin
                    m_active = 0;
                    m_zdone  = cyc + 1;
                end
            end
            cyc++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    function automatic logic [5:0] lb(input int n);
        return (n < LOGN) ? log_btn[n] : 6'h3f;
    endfunction

    int a, d, p, g, nd;

    initial begin
        p = SMS * TDIV;
        g = GMS * TDIV;
        rst = 1'b1; cmd_valid = 1'b0; cmd_mask = '0; cmd_long = 1'b0;
        step(3);
        chk("reset button_out", 32'(button_out), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        rst = 1'b0;
        step(2);

        // Short press
        a = cyc; cmd_valid = 1'b1; cmd_mask = 6'b000101; cmd_long = 1'b0;
        step(1);
        cmd_valid = 1'b0;
        step(p + g + 4);
        chk("short first cycle", 32'(lb(a + 1)), 32'(6'b000101));
        chk("short last press cycle", 32'(lb(a + p)), 32'(6'b000101));
        chk("short gap start", 32'(lb(a + p + 1)), 32'd0);
`ifdef PRESS_BOUNCE_EN
        chk("bounce slot1", 32'(lb(a + 5)), 32'd0);
        chk("bounce slot2", 32'(lb(a + 9)), 32'(6'b000101));
        chk("bounce slot3", 32'(lb(a + 16)), 32'd0);
        chk("bounce steady", 32'(lb(a + 17)), 32'(6'b000101));
        chk("short done cycle", 32'(log_done[a + 28]), 32'd1);
`else
        chk("short done cycle", 32'(log_done[a + 20]), 32'd1);
        chk("short ready at done", 32'(log_ready[a + 20]), 32'd1);
        chk("short no early done", 32'(log_done[a + 19]), 32'd0);
        chk("short busy last gap", 32'(log_busy[a + 19]), 32'd1);
`endif

        // Long press, with a changing mask while busy that must be ignored
        a = cyc; cmd_valid = 1'b1; cmd_mask = 6'b100000; cmd_long = 1'b1;
        step(1);
        cmd_valid = 1'b0; cmd_mask = 6'b111111;
        step(52);
        chk("long press end", 32'(lb(a + 40)), 32'(6'b100000));
        chk("long gap start", 32'(lb(a + 41)), 32'd0);
        chk("long done", 32'(log_done[a + 48]), 32'd1);
        chk("long done not early", 32'(log_done[a + 47]), 32'd0);
        chk("long busy mid", 32'(log_busy[a + 30]), 32'd1);

        // Back-to-back with cmd_valid held
        a = cyc; cmd_valid = 1'b1; cmd_mask = 6'b000011; cmd_long = 1'b0;
        step(1);
        cmd_mask = 6'b001100;
        step(p + g);
        cmd_valid = 1'b0;
        step(p + g + 4);
        d = a + p + g;
        chk("b2b first mask", 32'(lb(a + 1)), 32'(6'b000011));
        chk("b2b first done", 32'(log_done[d]), 32'd1);
        chk("b2b idle at done", 32'(lb(d)), 32'd0);
        chk("b2b second mask", 32'(lb(d + 1)), 32'(6'b001100));
        chk("b2b second done", 32'(log_done[d + p + g]), 32'd1);

        // Zero mask
        a = cyc; cmd_valid = 1'b1; cmd_mask = 6'b000000; cmd_long = 1'b0;
        step(1);
        cmd_valid = 1'b0;
        step(3);
        chk("zero done next", 32'(log_done[a + 1]), 32'd1);
        chk("zero not busy", 32'(log_busy[a + 1]), 32'd0);
        chk("zero done single", 32'(log_done[a + 2]), 32'd0);

        // Reset in the middle of a short press
        a = cyc; cmd_valid = 1'b1; cmd_mask = 6'b000101; cmd_long = 1'b0;
        step(1);
        cmd_valid = 1'b0;
        step(5);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(30);
        chk("rst pressed before", 32'(lb(a + 6)), 32'(6'b000101));
        chk("rst drops button", 32'(lb(a + 7)), 32'd0);
        chk("rst drops busy", 32'(log_busy[a + 7]), 32'd0);
        chk("rst ready after", 32'(log_ready[a + 7]), 32'd1);
        nd = 0;
        for (int i = a + 7; i < a + 36; i++) nd += int'(log_done[i]);
        chk("rst no done", 32'(nd), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
